// File: rtl/gated_clock_monitor_if.sv
// Bundle of the monitored gated clock, its error-clear input and the
// lock/measurement status returned by gated_clock_monitor.
interface gated_clock_monitor_if #(
  parameter int CNT_W = 8
);
  logic             gclk_in;
  logic             clear;
  logic             edge_pulse;
  logic             clk_valid;
  logic [CNT_W-1:0] half_period;
  logic             period_err;

  modport master (
    output gclk_in, clear,
    input  edge_pulse, clk_valid, half_period, period_err
  );

  modport slave (
    input  gclk_in, clear,
    output edge_pulse, clk_valid, half_period, period_err
  );
endinterface

// File: rtl/gated_clock_monitor.sv
// Receive-side lock detector for a valid-gated clock: synchronizes gclk_in,
// measures the half-period between transitions and locks after a stable run.
module gated_clock_monitor #(
  parameter int CNT_W       = 8,
  parameter int LOCK_CYCLES = 4,
  parameter int TOLERANCE   = 1,
  parameter int TIMEOUT     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gated_clock_monitor_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FIRST, ACQUIRE, LOCKED} state_t;

  localparam logic [CNT_W-1:0]        CNT_MAX = '1;
  localparam logic [CNT_W-1:0]        TO_P    = CNT_W'(TIMEOUT);
  localparam logic signed [CNT_W:0]   TOL_P   = (CNT_W+1)'(TOLERANCE);
  localparam logic [3:0]              LOCK_P  = 4'(LOCK_CYCLES);

  logic [2:0]       sync_pipe;
  logic             edge_det;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ref_q, ref_d;
  logic [3:0]       mcnt_q, mcnt_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0]    interval;
  logic signed [CNT_W:0] diff;
  logic                match;
  logic [3:0]          mcnt_inc;
  logic                bad;

  // sync_pipe[0] is the metastability flop; edges are taken from the later two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[1:0], bus.gclk_in};
  end

  assign edge_det = sync_pipe[1] ^ sync_pipe[2];

  assign interval = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign diff     = $signed({1'b0, interval}) - $signed({1'b0, ref_q});
  assign match    = (diff <= TOL_P) && (diff >= -TOL_P);
  assign mcnt_inc = mcnt_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ref_q   <= '0;
      mcnt_q  <= '0;
      hp_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      mcnt_q  <= mcnt_d;
      hp_q    <= hp_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    mcnt_d  = mcnt_q;
    hp_d    = hp_q;
    valid_d = valid_q;
    bad     = 1'b0;
    cnt_d   = edge_det ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);

    if (edge_det) begin
      case (state_q)
        IDLE: state_d = FIRST;
        FIRST: begin
          ref_d   = interval;
          mcnt_d  = '0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (match) begin
            mcnt_d = mcnt_inc;
            if (mcnt_inc == LOCK_P) begin
              state_d = LOCKED;
              hp_d    = ref_q;
              valid_d = 1'b1;
            end
          end else begin
            ref_d  = interval;
            mcnt_d = '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            bad     = 1'b1;
            valid_d = 1'b0;
            ref_d   = interval;
            mcnt_d  = '0;
            state_d = ACQUIRE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && cnt_q == TO_P) begin
      // source gated off: an edge landing on the same cycle takes the branch above
      state_d = IDLE;
      valid_d = 1'b0;
      mcnt_d  = '0;
    end

    // a fresh error outranks a simultaneous clear
    if (bad)            err_d = 1'b1;
    else if (bus.clear) err_d = 1'b0;
    else                err_d = err_q;
  end

  assign bus.edge_pulse  = edge_det;
  assign bus.clk_valid   = valid_q;
  assign bus.half_period = hp_q;
  assign bus.period_err  = err_q;

endmodule

// File: tb/tb_gated_clock_monitor.sv
// Scoreboarded bench: each gclk_in toggle pushes the predicted status, which
// is compared one cycle after the matching edge_pulse.
module tb_gated_clock_monitor;
  localparam int CNT_W = 8, LOCK = 4, TOL = 1, TMO = 16;
  localparam int TMO2 = 12;
  localparam int S_IDLE = 0, S_FIRST = 1, S_ACQ = 2, S_LOCK = 3;

  typedef struct {
    bit v;
    int hp;
    bit err;
    bit clr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_main = 1'b0;
  logic clr_mon = 1'b0;

  always #5 clk = ~clk;

  gated_clock_monitor_if #(.CNT_W(CNT_W)) bus();
  gated_clock_monitor_if #(.CNT_W(4))     bus2();

  assign bus.clear  = clr_main | clr_mon;
  assign bus2.clear = 1'b0;

  gated_clock_monitor #(.CNT_W(CNT_W), .LOCK_CYCLES(LOCK), .TOLERANCE(TOL), .TIMEOUT(TMO))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  gated_clock_monitor #(.CNT_W(4), .LOCK_CYCLES(LOCK), .TOLERANCE(TOL), .TIMEOUT(TMO2))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int n_chk = 0;
  int n_err = 0;
  exp_t sb[$];

  int ms = S_IDLE, mref = 0, mm = 0, mhp = 0;
  bit mv = 0, merr = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Interval-level model of the lock behaviour; g is the toggle spacing in clk cycles.
  task automatic predict(input int g, input bit clr);
    int iv;
    bit m, bad;
    exp_t e;
    bad = 0;
    if (ms != S_IDLE && g - 2 >= TMO) begin
      ms = S_IDLE; mv = 0; mm = 0;
    end
    iv = (g > 255) ? 255 : g;
    m  = (iv - mref <= TOL) && (mref - iv <= TOL);
    case (ms)
      S_IDLE:  ms = S_FIRST;
      S_FIRST: begin mref = iv; mm = 0; ms = S_ACQ; end
      S_ACQ: begin
        if (m) begin
          mm++;
          if (mm == LOCK) begin ms = S_LOCK; mhp = mref; mv = 1; end
        end else begin
          mref = iv; mm = 0;
        end
      end
      default: begin
        if (!m) begin bad = 1; mv = 0; mref = iv; mm = 0; ms = S_ACQ; end
      end
    endcase
    if (bad) merr = 1;
    else if (clr) merr = 0;
    e.v = mv; e.hp = mhp; e.err = merr; e.clr = clr;
    sb.push_back(e);
  endtask

  // pg overrides the spacing the model sees (used after a gated-off stretch)
  task automatic step(input int g, input bit clr = 0, input int pg = -1);
    repeat (g) @(negedge clk);
    bus.gclk_in = ~bus.gclk_in;
    predict((pg < 0) ? g : pg, clr);
  endtask

  task automatic step2(input int g);
    repeat (g) @(negedge clk);
    bus2.gclk_in = ~bus2.gclk_in;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.edge_pulse) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          clr_mon = e.clr;
          @(negedge clk);
          clr_mon = 1'b0;
          chk("clk_valid", bus.clk_valid, e.v);
          chk("half_period", bus.half_period, e.hp);
          chk("period_err", bus.period_err, e.err);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int ne;
    bus.gclk_in  = 1'b0;
    bus2.gclk_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.clk_valid, 0);
    chk("rst_hp", bus.half_period, 0);
    chk("rst_err", bus.period_err, 0);
    chk("rst_edge", bus.edge_pulse, 0);
    rst_n = 1'b1;

    // steady lock at 5; lock lands on the 6th edge
    repeat (8) step(5);

    // tolerance: 6,4,5 stay locked, 8 errors, then relock at 8
    step(6); step(4); step(5); step(8);
    repeat (6) step(8);

    // gate-off with gclk_in low: valid holds until cnt reaches TIMEOUT
    repeat (TMO + 3) @(negedge clk);
    chk("to_hold_valid", bus.clk_valid, 1);
    @(negedge clk);
    chk("to_drop_valid", bus.clk_valid, 0);
    chk("to_state_idle", dut.state_q, S_IDLE);

    // clear on its own
    chk("err_before_clr", bus.period_err, 1);
    clr_main = 1'b1;
    @(negedge clk);
    clr_main = 1'b0;
    chk("clr_alone", bus.period_err, 0);
    merr = 0;

    // re-enable: relock at 5 after 6 edges
    step(5, 0, 99);
    repeat (7) step(5);

    // clear together with an out-of-tolerance edge
    step(9, 1);
    repeat (6) step(9);

    // async reset while locked
    repeat (4) @(negedge clk);
    chk("pre_rst_valid", bus.clk_valid, 1);
    chk("pre_rst_hp", bus.half_period, 9);
    bus.gclk_in = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", bus.clk_valid, 0);
    chk("async_hp", bus.half_period, 0);
    chk("async_err", bus.period_err, 0);
    chk("async_edge", bus.edge_pulse, 0);
    sb.delete();
    ms = S_IDLE; mref = 0; mm = 0; mhp = 0; mv = 0; merr = 0;
    @(negedge clk);
    predict(1, 0);
    rst_n = 1'b1;
    ne = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.edge_pulse) ne++;
    end
    chk("rel_edges", ne, 1);
    chk("rel_state_first", dut.state_q, S_FIRST);

    // saturation instance: CNT_W=4, half-period 10, TIMEOUT 12
    repeat (8) step2(10);
    repeat (3) @(negedge clk);
    chk("sat_valid", bus2.clk_valid, 1);
    chk("sat_hp", bus2.half_period, 10);
    chk("sat_err", bus2.period_err, 0);
    repeat (TMO2) @(negedge clk);
    chk("sat_to_hold", bus2.clk_valid, 1);
    @(negedge clk);
    chk("sat_to_drop", bus2.clk_valid, 0);
    repeat (10) @(negedge clk);
    chk("sat_cnt_clamped", dut2.cnt_q, 15);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
